// File: rtl/hs_arith_dispatch_pkg.sv
// Shared types and helpers for the minimum-load dispatcher.
// Load width is chosen per instance, so the load type is built by macro.
`ifndef HS_ARITH_DISPATCH_PKG_SV
`define HS_ARITH_DISPATCH_PKG_SV

`define HS_LOAD_T(w) logic [(w)-1:0]

package hs_arith_dispatch_pkg;

    localparam int DEF_LOAD_WIDTH = 8;

    typedef `HS_LOAD_T(DEF_LOAD_WIDTH) load_t;

    // True when the lower-index candidate should be kept over the higher one.
    function automatic logic keep_lower(
        input logic        lo_ok,
        input logic        hi_ok,
        input logic [31:0] lo_load,
        input logic [31:0] hi_load
    );
        return lo_ok && (!hi_ok || lo_load <= hi_load);
    endfunction

endpackage

`endif

// File: rtl/hs_arith_load_counter.sv
// Saturating up/down outstanding-work counter for one dispatch channel.
// underflow_o flags a decrement seen while the count is already zero.
module hs_arith_load_counter
    import hs_arith_dispatch_pkg::*;
#(
    parameter int W   = 8,
    parameter int MAX = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         at_max_o,
    output logic         underflow_o
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    `HS_LOAD_T(W) count_q;
    `HS_LOAD_T(W) count_d;

    assign at_max_o    = (count_q >= MAX_C);
    assign underflow_o = dec_i && (count_q == '0);
    assign count_o     = count_q;

    // inc and dec together cancel, including the zero-count case
    always_comb begin
        count_d = count_q;
        unique case ({inc_i, dec_i})
            2'b10: if (!at_max_o) count_d = count_q + 1'b1;
            2'b01: if (!underflow_o) count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hs_arith_min_load_dispatcher.sv
// 1-to-N dispatcher: each beat goes to the eligible channel with least load.
// s_ready/s_index are combinational from m_ready and ch_enable.
module hs_arith_min_load_dispatcher
    import hs_arith_dispatch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OUTPUT_NUM = 4,
    parameter int LOAD_WIDTH = 8,
    parameter int MAX_LOAD   = 2**LOAD_WIDTH - 1,
    localparam int INDEX_WIDTH = $clog2(OUTPUT_NUM)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [DATA_WIDTH-1:0]                  s_data,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    output logic [INDEX_WIDTH-1:0]                 s_index,
    input  logic [OUTPUT_NUM-1:0]                  ch_enable,
    output logic [OUTPUT_NUM-1:0][DATA_WIDTH-1:0]  m_data,
    output logic [OUTPUT_NUM-1:0]                  m_valid,
    input  logic [OUTPUT_NUM-1:0]                  m_ready,
    input  logic [OUTPUT_NUM-1:0]                  done,
    output logic [OUTPUT_NUM-1:0][LOAD_WIDTH-1:0]  load,
    output logic                                   err_underflow
);

    logic [OUTPUT_NUM-1:0]                 elig;
    logic [OUTPUT_NUM-1:0]                 at_max;
    logic [OUTPUT_NUM-1:0]                 uflow;
    logic [OUTPUT_NUM-1:0]                 acc_oh;
    logic [OUTPUT_NUM-1:0][DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [OUTPUT_NUM-1:0]                 m_valid_q, m_valid_d;
    logic                                  err_q, err_d;
    logic [INDEX_WIDTH-1:0]                tgt;
    logic                                  any_ok;
    logic                                  accept;
    `HS_LOAD_T(LOAD_WIDTH)                 best_load;

    for (genvar g = 0; g < OUTPUT_NUM; g++) begin : g_ch
        hs_arith_load_counter #(
            .W   (LOAD_WIDTH),
            .MAX (MAX_LOAD)
        ) u_cnt (
            .clk         (clk),
            .rst_n       (rst_n),
            .inc_i       (acc_oh[g]),
            .dec_i       (done[g]),
            .count_o     (load[g]),
            .at_max_o    (at_max[g]),
            .underflow_o (uflow[g])
        );

        assign elig[g] = ch_enable[g] & ~at_max[g]
                       & (~m_valid_q[g] | m_ready[g]);
    end

    // Scan upward; a later channel wins only on strictly lower load
    always_comb begin
        tgt       = '0;
        any_ok    = 1'b0;
        best_load = '0;
        for (int i = 0; i < OUTPUT_NUM; i++) begin
            if (elig[i] && !keep_lower(any_ok, 1'b1,
                                       32'(best_load), 32'(load[i]))) begin
                any_ok    = 1'b1;
                tgt       = INDEX_WIDTH'(i);
                best_load = load[i];
            end
        end
    end

    assign accept  = s_valid & any_ok;
    assign s_ready = any_ok;
    assign s_index = tgt;

    always_comb begin
        acc_oh    = '0;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        for (int i = 0; i < OUTPUT_NUM; i++) begin
            acc_oh[i] = accept && (tgt == INDEX_WIDTH'(i));
            if (acc_oh[i]) begin
                m_valid_d[i] = 1'b1;
                m_data_d[i]  = s_data;
            end else if (m_ready[i]) begin
                m_valid_d[i] = 1'b0;
            end
        end
    end

    assign err_d = err_q | (|uflow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= '0;
            m_data_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            err_q     <= err_d;
        end
    end

    assign m_valid       = m_valid_q;
    assign m_data        = m_data_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_hs_arith_min_load_dispatcher.sv
// Bench for hs_arith_min_load_dispatcher: default and LOAD_WIDTH=2 instances
// share stimulus and are compared each cycle against a behavioural model.
module tb_hs_arith_min_load_dispatcher;

    logic        clk;
    logic        rst_n;
    logic [31:0] s_data;
    logic        s_valid;
    logic [3:0]  ch_en;
    logic [3:0]  m_rdy;
    logic [3:0]  done;

    logic             s_ready0, s_ready1;
    logic [1:0]       s_index0, s_index1;
    logic [3:0][31:0] m_data0, m_data1;
    logic [3:0]       m_valid0, m_valid1;
    logic [3:0][7:0]  load0;
    logic [3:0][1:0]  load1;
    logic             err0, err1;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 0;

    int          ml[2][4];
    bit          mv[2][4];
    logic [31:0] md[2][4];
    bit          me[2];

    hs_arith_min_load_dispatcher dut0 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready0), .s_index(s_index0), .ch_enable(ch_en),
        .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_rdy),
        .done(done), .load(load0), .err_underflow(err0)
    );

    hs_arith_min_load_dispatcher #(.LOAD_WIDTH(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready1), .s_index(s_index1), .ch_enable(ch_en),
        .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_rdy),
        .done(done), .load(load1), .err_underflow(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: least-loaded eligible channel, lowest index on ties
    task automatic pick(input int k, output bit ok, output int t);
        int maxl;
        maxl = (k == 0) ? 255 : 3;
        ok = 0;
        t  = 0;
        for (int i = 0; i < 4; i++) begin
            if (ch_en[i] && ml[k][i] < maxl && (!mv[k][i] || m_rdy[i])) begin
                if (!ok || ml[k][i] < ml[k][t]) begin
                    ok = 1;
                    t  = i;
                end
            end
        end
    endtask

    task automatic model_step(input int k);
        bit ok;
        int t;
        bit a;
        int nl;
        pick(k, ok, t);
        for (int i = 0; i < 4; i++) begin
            a  = ok && s_valid && (t == i);
            nl = ml[k][i] + (a ? 1 : 0) - (done[i] ? 1 : 0);
            if (done[i] && ml[k][i] == 0) me[k] = 1;
            if (nl < 0) nl = 0;
            ml[k][i] = nl;
            if (a) begin
                mv[k][i] = 1;
                md[k][i] = s_data;
            end else if (m_rdy[i]) begin
                mv[k][i] = 0;
            end
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            me[k] = 0;
            for (int i = 0; i < 4; i++) begin
                ml[k][i] = 0;
                mv[k][i] = 0;
                md[k][i] = '0;
            end
        end
    endtask

    initial model_clear();

    always @(negedge rst_n) model_clear();

    always @(posedge clk) begin
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            bit ok;
            int t;
            pick(0, ok, t);
            chk("s_ready0", 64'(s_ready0), 64'(ok));
            if (ok) chk("s_index0", 64'(s_index0), 64'(t));
            pick(1, ok, t);
            chk("s_ready1", 64'(s_ready1), 64'(ok));
            if (ok) chk("s_index1", 64'(s_index1), 64'(t));
            chk("err0", 64'(err0), 64'(me[0]));
            chk("err1", 64'(err1), 64'(me[1]));
            for (int i = 0; i < 4; i++) begin
                chk("m_valid0", 64'(m_valid0[i]), 64'(mv[0][i]));
                chk("m_valid1", 64'(m_valid1[i]), 64'(mv[1][i]));
                chk("m_data0", 64'(m_data0[i]), 64'(md[0][i]));
                chk("m_data1", 64'(m_data1[i]), 64'(md[1][i]));
                chk("load0", 64'(load0[i]), 64'(ml[0][i]));
                chk("load1", 64'(load1[i]), 64'(ml[1][i]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] e, input int n);
        ch_en   = e;
        s_valid = 1'b1;
        repeat (n) begin
            s_data = $urandom;
            step();
        end
        s_valid = 1'b0;
    endtask

    task automatic drain();
        bit busy;
        s_valid = 1'b0;
        ch_en   = 4'hF;
        m_rdy   = 4'hF;
        busy    = 1;
        for (int c = 0; c < 300 && busy; c++) begin
            busy = 0;
            for (int i = 0; i < 4; i++) begin
                done[i] = (ml[0][i] > 0);
                if (ml[0][i] > 0) busy = 1;
            end
            if (busy) step();
        end
        done = '0;
        chk("drain", 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        ch_en   = 4'hF;
        m_rdy   = 4'hF;
        done    = '0;
        #8;
        chk("rst_mvalid", 64'(m_valid0), 64'd0);
        chk("rst_load", 64'(load0), 64'd0);
        chk("rst_err", 64'(err0), 64'd0);
        #4 rst_n = 1'b1;
        step();
        chk_on = 1;

        // round robin by load on equal loads
        s_valid = 1'b1;
        for (int b = 0; b < 8; b++) begin
            s_data = 32'hA0 + 32'(b);
            #1;
            chk("rr_index", 64'(s_index0), 64'(b % 4));
            step();
            chk("rr_mvalid", 64'(m_valid0[b % 4]), 64'd1);
            chk("rr_mdata", 64'(m_data0[b % 4]), 64'hA0 + 64'(b));
        end
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) chk("rr_load", 64'(load0[i]), 64'd2);
        drain();

        // tie between ch1 and ch2 resolves low
        send(4'b0001, 3);
        send(4'b0010, 1);
        send(4'b0100, 1);
        send(4'b1000, 2);
        ch_en   = 4'hF;
        s_valid = 1'b1;
        s_data  = 32'h55;
        #1;
        chk("tie_index", 64'(s_index0), 64'd1);
        step();
        s_valid = 1'b0;
        chk("tie_l0", 64'(load0[0]), 64'd3);
        chk("tie_l1", 64'(load0[1]), 64'd2);
        chk("tie_l2", 64'(load0[2]), 64'd1);
        chk("tie_l3", 64'(load0[3]), 64'd2);
        chk("tie_data", 64'(m_data0[1]), 64'h55);
        drain();

        // stalled slot, then back-to-back on release
        m_rdy   = 4'b1110;
        ch_en   = 4'b0001;
        s_valid = 1'b1;
        s_data  = 32'h11;
        step();
        s_data = 32'h22;
        #1;
        chk("stall_ready", 64'(s_ready0), 64'd0);
        step();
        chk("stall_hold", 64'(m_data0[0]), 64'h11);
        m_rdy = 4'hF;
        #1;
        chk("rel_ready", 64'(s_ready0), 64'd1);
        step();
        s_valid = 1'b0;
        chk("b2b_data", 64'(m_data0[0]), 64'h22);
        chk("b2b_valid", 64'(m_valid0[0]), 64'd1);
        drain();

        // inc+dec cancel, then underflow is sticky
        send(4'b0100, 1);
        s_valid = 1'b1;
        done    = 4'b0100;
        step();
        s_valid = 1'b0;
        chk("incdec_l2", 64'(load0[2]), 64'd1);
        step();
        step();
        done = '0;
        chk("uf_l2", 64'(load0[2]), 64'd0);
        chk("uf_err", 64'(err0), 64'd1);
        step();
        chk("uf_sticky", 64'(err0), 64'd1);
        drain();

        // saturation on the narrow instance
        send(4'b0001, 3);
        #1;
        chk("sat_load", 64'(load1[0]), 64'd3);
        chk("sat_ready", 64'(s_ready1), 64'd0);
        done = 4'b0001;
        step();
        done = '0;
        #1;
        chk("sat_release", 64'(s_ready1), 64'd1);
        drain();

        // async reset mid-stream
        send(4'b0001, 2);
        send(4'b1000, 3);
        m_rdy = 4'b1101;
        send(4'b0010, 1);
        chk("pre_rst_mv1", 64'(m_valid0[1]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mvalid", 64'(m_valid0), 64'd0);
        chk("arst_load", 64'(load0), 64'd0);
        chk("arst_err", 64'(err0), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();
        ch_en   = 4'hF;
        m_rdy   = 4'hF;
        s_valid = 1'b1;
        s_data  = 32'h77;
        #1;
        chk("post_rst_idx", 64'(s_index0), 64'd0);
        step();
        s_valid = 1'b0;
        chk("post_rst_data", 64'(m_data0[0]), 64'h77);

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = $urandom;
            ch_en   = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                m_rdy[i] = ($urandom_range(0, 3) != 0);
                done[i]  = ($urandom_range(0, 4) == 0);
            end
            step();
        end
        s_valid = 1'b0;
        done    = '0;
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
